pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges the load-use hazard flag,
//  taken-branch flush, multi-cycle multiply/divide (MDU) occupancy and data-memory wait
//  states. Produces per-stage hold/bubble/flush controls. Sits beside the hazard detection
//  unit; its outputs drive the PC and the IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//  MDU_LATENCY  4   cycles the MDU op occupies EX (>=1)
//  MEM_TIMEOUT  16  max consecutive dmem wait cycles before fault (>=2)
//  CNT_W        16  width of stall_count
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous, active-low reset
//  load_use_hz   in   1      load in EX feeds instr in ID
//  branch_taken  in   1      branch resolved taken in ID
//  mdu_start     in   1      MULT/DIV instr in EX this cycle
//  dmem_req      in   1      MEM-stage access active
//  dmem_ready    in   1      data memory completes access this cycle
//  pc_hold       out  1      freeze PC
//  ifid_hold     out  1      freeze IF/ID
//  ifid_flush    out  1      zero IF/ID (squash fetched instr)
//  idex_hold     out  1      freeze ID/EX
//  idex_bubble   out  1      load NOP into ID/EX
//  exmem_hold    out  1      freeze EX/MEM
//  exmem_bubble  out  1      load NOP into EX/MEM
//  mdu_done      out  1      1-cycle pulse, MDU result valid in EX
//  timeout_err   out  1      sticky dmem timeout fault
//  stall_count   out  CNT_W  saturating count of cycles with pc_hold=1
// BEHAVIOUR
//  Registered FSM (RUN, MDU, MEM, ERR). Outputs are combinational from state, counters and
//  inputs. Reset: state=RUN, mdu_cnt=0, wait_cnt=0, stall_count=0, timeout_err=0; all
//  outputs 0 while inputs are 0. Reset mid-operation aborts to RUN with no mdu_done.
//  RUN priority (highest first):
//   1 dmem_req&&!dmem_ready: pc/ifid/idex/exmem_hold=1; next MEM, wait_cnt<=1.
//   2 mdu_start: pc/ifid/idex_hold=1, exmem_bubble=1; next MDU, mdu_cnt<=MDU_LATENCY-1.
//   3 load_use_hz: pc_hold=ifid_hold=1, idex_bubble=1; ifid_flush suppressed even if
//     branch_taken (branch re-resolves next cycle); stay RUN.
//   4 branch_taken: ifid_flush=1 only; stay RUN.
//   dmem_req&&dmem_ready in RUN = zero-wait access: no stall.
//  MDU: mdu_cnt!=0 -> pc/ifid/idex_hold=1, exmem_bubble=1, mdu_cnt--.
//   mdu_cnt==0 -> no holds, mdu_done=1, next RUN. Total stall = MDU_LATENCY cycles, then
//   one done cycle. load_use_hz, branch_taken, mdu_start, dmem_req ignored (MEM holds bubbles).
//  MEM: all four holds=1 while !dmem_ready; wait_cnt++ each cycle.
//   dmem_ready=1 -> holds released same cycle, next RUN, wait_cnt<=0 (ready wins over timeout).
//   !dmem_ready && wait_cnt==MEM_TIMEOUT-1 -> next ERR.
//   Other inputs ignored in MEM.
//  ERR: all four holds=1, timeout_err=1, flush/bubble/done=0; exit only via rst_n.
//  Bubble/flush never coincide with hold on the same register.
//  stall_count increments on every cycle with pc_hold=1 (ERR included) and sticks at
//  2^CNT_W-1.
// TESTING
//  T1 load_use_hz=1 for 1 cycle in RUN -> pc_hold=ifid_hold=idex_bubble=1 that cycle,
//     stall_count=1.
//  T2 load_use_hz=1 and branch_taken=1 together -> ifid_flush=0, idex_bubble=1;
//     next cycle branch_taken only -> ifid_flush=1.
//  T3 mdu_start pulse, MDU_LATENCY=4 -> holds+exmem_bubble for 4 cycles, mdu_done=1 on
//     5th cycle, then RUN.
//  T4 dmem_req=1, dmem_ready low 3 cycles then high -> holds=1 for 3 cycles, released on
//     ready cycle, stall_count=3.
//  T5 dmem_ready low for 16 cycles -> ERR, timeout_err=1 sticky, holds stay 1;
//     rst_n low -> all outputs 0.
//  T6 rst_n asserted at mdu_cnt=2 -> RUN, no mdu_done; T7 CNT_W=4 with 20 stall cycles
//     -> stall_count=15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch flush,
// MDU occupancy and data-memory wait states into per-stage hold/bubble/flush controls.
module pipeline_stall_controller #(
  parameter int MDU_LATENCY = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hz_i,
  input  logic             branch_taken_i,
  input  logic             mdu_start_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_hold_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic             exmem_bubble_o,
  output logic             mdu_done_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int MW = $clog2(MDU_LATENCY + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_MDU, S_MEM, S_ERR} state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             dmem_miss;

  assign dmem_miss = dmem_req_i && !dmem_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      mdu_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mdu_cnt_q  <= mdu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mdu_cnt_d  = mdu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (dmem_miss) begin
          state_d    = S_MEM;
          wait_cnt_d = WW'(1);
        end else if (mdu_start_i) begin
          state_d   = S_MDU;
          mdu_cnt_d = MW'(MDU_LATENCY - 1);
        end
      end
      S_MDU: begin
        if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - MW'(1);
        else                 state_d   = S_RUN;
      end
      S_MEM: begin
        // ready wins over the timeout on the same cycle
        if (dmem_ready_i) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
          if (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) state_d = S_ERR;
        end
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_hold_o      = 1'b0;
    ifid_hold_o    = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_hold_o    = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    exmem_bubble_o = 1'b0;
    mdu_done_o     = 1'b0;
    timeout_err_o  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (dmem_miss) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          idex_hold_o  = 1'b1;
          exmem_hold_o = 1'b1;
        end else if (mdu_start_i) begin
          pc_hold_o      = 1'b1;
          ifid_hold_o    = 1'b1;
          idex_hold_o    = 1'b1;
          exmem_bubble_o = 1'b1;
        end else if (load_use_hz_i) begin
          // branch flush deferred: the branch re-resolves once the load-use clears
          pc_hold_o     = 1'b1;
          ifid_hold_o   = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
        end
      end
      S_MDU: begin
        if (mdu_cnt_q != '0) begin
          pc_hold_o      = 1'b1;
          ifid_hold_o    = 1'b1;
          idex_hold_o    = 1'b1;
          exmem_bubble_o = 1'b1;
        end else begin
          mdu_done_o = 1'b1;
        end
      end
      S_MEM: begin
        if (!dmem_ready_i) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          idex_hold_o  = 1'b1;
          exmem_hold_o = 1'b1;
        end
      end
      S_ERR: begin
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
        idex_hold_o   = 1'b1;
        exmem_hold_o  = 1'b1;
        timeout_err_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cnt_q <= '0;
    else if (pc_hold_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a cycle-level reference model
// predicts every cycle's controls; a negedge monitor pops and compares.
module tb_pipeline_stall_controller;

  localparam int LAT = 4;
  localparam int TO  = 16;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu = 1'b0, br = 1'b0, ms = 1'b0, req = 1'b0, rdy = 1'b0;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;
  logic exmem_hold, exmem_bubble, mdu_done, timeout_err;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MDU_LATENCY(LAT), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_hz_i(lu), .branch_taken_i(br), .mdu_start_i(ms),
    .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold), .ifid_flush_o(ifid_flush),
    .idex_hold_o(idex_hold), .idex_bubble_o(idex_bubble),
    .exmem_hold_o(exmem_hold), .exmem_bubble_o(exmem_bubble),
    .mdu_done_o(mdu_done), .timeout_err_o(timeout_err), .stall_count_o(stall_count)
  );

  typedef struct packed {
    logic [8:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: mode 0 normal, 1 multiply/divide busy, 2 waiting on memory, 3 faulted
  int mode, mdu_age, waits, stall_total;

  task automatic model_reset();
    mode = 0; mdu_age = 0; waits = 0; stall_total = 0;
  endtask

  // ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, exmem_bubble, mdu_done, timeout_err}
  task automatic model_cycle(output exp_t e);
    logic [8:0] c;
    c = '0;
    case (mode)
      3: c = 9'b110101001;
      2: begin
        if (rdy) mode = 0;
        else begin
          c = 9'b110101000;
          waits++;
          if (waits == TO) mode = 3;
        end
      end
      1: begin
        if (mdu_age < LAT) begin
          c = 9'b110100100;
          mdu_age++;
        end else begin
          c = 9'b000000010;
          mode = 0;
        end
      end
      default: begin
        if (req && !rdy) begin
          c = 9'b110101000; mode = 2; waits = 1;
        end else if (ms) begin
          c = 9'b110100100; mode = 1; mdu_age = 1;
        end else if (lu) begin
          c = 9'b110010000;
        end else if (br) begin
          c = 9'b001000000;
        end
      end
    endcase
    e.ctl = c;
    e.cnt = CW'((stall_total > SAT) ? SAT : stall_total);
    if (c[8]) stall_total++;
  endtask

  task automatic step(input logic l, input logic b, input logic m, input logic rq, input logic rd);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b1; lu = l; br = b; ms = m; req = rq; rdy = rd;
    model_cycle(e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0; lu = 0; br = 0; ms = 0; req = 0; rdy = 0;
    model_reset();
    e.ctl = '0; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [8:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
             exmem_hold, exmem_bubble, mdu_done, timeout_err};
      n_cmp++;
      if (got !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
      end
      n_cmp++;
      if (stall_count !== e.cnt) begin
        n_bad++;
        $display("FAIL stall_count t=%0t got=%0d want=%0d", $time, stall_count, e.cnt);
      end
    end
  end

  initial begin
    int p_rdy;
    model_reset();
    do_reset();
    // load-use alone, then with branch, then branch alone
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // MDU op with distractor inputs during occupancy
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // three wait states then ready
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    // zero-wait access is not a stall
    step(0, 0, 0, 1, 1);
    // timeout into sticky fault
    do_reset();
    for (int i = 0; i < TO; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
    // reset mid-MDU: no done pulse afterwards
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // counter saturation after 20 stall cycles
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // randomized segments with varying memory readiness
    for (int s = 0; s < 30; s++) begin
      do_reset();
      case (s % 4)
        0: p_rdy = 5;
        1: p_rdy = 40;
        2: p_rdy = 80;
        default: p_rdy = 100;
      endcase
      for (int i = 0; i < 60; i++)
        step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
             ($urandom % 2) == 0, $urandom_range(0, 99) < p_rdy);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
